// File: rtl/rf_wb_buffer_pkg.sv
// Shared defaults and helpers for the register-file writeback buffer.
// Build switch: NCPU_WB_BYPASS_EN enables the BYP_* lookup ports.
package rf_wb_buffer_pkg;

   localparam int WB_DW        = 64;
   localparam int WB_AW        = 5;
   localparam int WB_NUM_WRITE = 2;
   localparam int WB_DEPTH     = 8;
   localparam int WB_NUM_READ  = 4;

   // ceil(log2(v)) for sizing pointers
   function automatic int log2c(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v)
            r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/rf_wb_age_match.sv
// One bypass lookup port: compares an address against an age-ordered
// candidate list (index 0 oldest) and returns the youngest match.
module rf_wb_age_match #(
   parameter int N  = 10,
   parameter int AW = 5,
   parameter int DW = 64
) (
   input  logic [AW-1:0]   raddr,
   input  logic [N-1:0]    valid,
   input  logic [N*AW-1:0] addr,
   input  logic [N*DW-1:0] data,
   output logic            hit,
   output logic [DW-1:0]   rdata
);

   // later candidates overwrite earlier ones, so the youngest match wins
   always_comb begin
      hit   = 1'b0;
      rdata = '0;
      for (int i = 0; i < N; i++) begin
         if (valid[i] && addr[i*AW +: AW] == raddr) begin
            hit   = 1'b1;
            rdata = data[i*DW +: DW];
         end
      end
   end

endmodule

// File: rtl/rf_wb_buffer.sv
// In-order writeback queue feeding the register-file write ports.
// Build switch: NCPU_WB_BYPASS_EN adds youngest-match bypass lookups.
module rf_wb_buffer
   import rf_wb_buffer_pkg::*;
#(
   parameter int DW        = WB_DW,
   parameter int AW        = WB_AW,
   parameter int NUM_WRITE = WB_NUM_WRITE,
   parameter int DEPTH     = WB_DEPTH
`ifdef NCPU_WB_BYPASS_EN
   ,
   parameter int NUM_READ  = WB_NUM_READ
`endif
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [NUM_WRITE-1:0]    IN_VALID,
   input  logic [NUM_WRITE*AW-1:0] IN_ADDR,
   input  logic [NUM_WRITE*DW-1:0] IN_DATA,
   output logic                    IN_READY,
   input  logic                    STALL,
   output logic [NUM_WRITE-1:0]    WE,
   output logic [NUM_WRITE*AW-1:0] WADDR,
   output logic [NUM_WRITE*DW-1:0] WDATA,
   output logic                    EMPTY
`ifdef NCPU_WB_BYPASS_EN
   ,
   input  logic [NUM_READ*AW-1:0]  BYP_RADDR,
   output logic [NUM_READ-1:0]     BYP_HIT,
   output logic [NUM_READ*DW-1:0]  BYP_DATA
`endif
);

   localparam int PW = log2c(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] npush;
   logic [CW-1:0] ndrain;
   logic          push;

   logic [AW-1:0] q_addr [DEPTH];
   logic [DW-1:0] q_data [DEPTH];

   // accept/drain amounts; drain sees only entries present before this push
   always_comb begin
      npush = '0;
      for (int i = 0; i < NUM_WRITE; i++)
         npush = npush + CW'(IN_VALID[i]);
      IN_READY = !RST && (count <= CW'(DEPTH - NUM_WRITE));
      push     = IN_READY && (|IN_VALID);
      if (STALL)
         ndrain = '0;
      else if (count < CW'(NUM_WRITE))
         ndrain = count;
      else
         ndrain = CW'(NUM_WRITE);
   end

   // queue storage; stale entries are harmless since count gates them
   always_ff @(posedge CLK) begin
      if (push) begin
         for (int i = 0; i < NUM_WRITE; i++) begin
            if (IN_VALID[i]) begin
               q_addr[wr_ptr + PW'(i)] <= IN_ADDR[i*AW +: AW];
               q_data[wr_ptr + PW'(i)] <= IN_DATA[i*DW +: DW];
            end
         end
      end
   end

   // pointers, occupancy and the registered RF write stage
   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         WE     <= '0;
         WADDR  <= '0;
         WDATA  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + npush[PW-1:0];
         rd_ptr <= rd_ptr + ndrain[PW-1:0];
         count  <= count + (push ? npush : '0) - ndrain;
         for (int i = 0; i < NUM_WRITE; i++) begin
            if (CW'(i) < ndrain) begin
               WE[i]               <= 1'b1;
               WADDR[i*AW +: AW]   <= q_addr[rd_ptr + PW'(i)];
               WDATA[i*DW +: DW]   <= q_data[rd_ptr + PW'(i)];
            end else begin
               WE[i]               <= 1'b0;
               WADDR[i*AW +: AW]   <= '0;
               WDATA[i*DW +: DW]   <= '0;
            end
         end
      end
   end

   assign EMPTY = (count == '0) && !(|WE);

   a_in_valid_packed: assert property (@(posedge CLK) disable iff (RST)
      ((IN_VALID & (IN_VALID + NUM_WRITE'(1))) == '0));

`ifdef NCPU_WB_BYPASS_EN
   localparam int NC = NUM_WRITE + DEPTH;

   logic [NC-1:0]    c_valid;
   logic [NC*AW-1:0] c_addr;
   logic [NC*DW-1:0] c_data;

   // age-ordered candidates: WE stage (oldest) then queue oldest..youngest
   always_comb begin
      c_valid = '0;
      c_addr  = '0;
      c_data  = '0;
      for (int i = 0; i < NUM_WRITE; i++) begin
         c_valid[i]           = WE[i];
         c_addr[i*AW +: AW]   = WADDR[i*AW +: AW];
         c_data[i*DW +: DW]   = WDATA[i*DW +: DW];
      end
      for (int k = 0; k < DEPTH; k++) begin
         c_valid[NUM_WRITE+k]             = CW'(k) < count;
         c_addr[(NUM_WRITE+k)*AW +: AW]   = q_addr[rd_ptr + PW'(k)];
         c_data[(NUM_WRITE+k)*DW +: DW]   = q_data[rd_ptr + PW'(k)];
      end
   end

   for (genvar g = 0; g < NUM_READ; g++) begin : g_byp
      rf_wb_age_match #(
         .N  (NC),
         .AW (AW),
         .DW (DW)
      ) u_match (
         .raddr (BYP_RADDR[g*AW +: AW]),
         .valid (c_valid),
         .addr  (c_addr),
         .data  (c_data),
         .hit   (BYP_HIT[g]),
         .rdata (BYP_DATA[g*DW +: DW])
      );
   end
`endif

endmodule

// File: tb/tb_rf_wb_buffer.sv
// Directed and model-checked bench for the writeback buffer.
// Bypass checks are built only when NCPU_WB_BYPASS_EN is defined.
module tb_rf_wb_buffer;

   localparam int DEPTH = 8;

   logic         clk;
   logic         rst;
   logic [1:0]   in_valid;
   logic [9:0]   in_addr;
   logic [127:0] in_data;
   logic         in_ready;
   logic         stall;
   logic [1:0]   we;
   logic [9:0]   waddr;
   logic [127:0] wdata;
   logic         empty;
`ifdef NCPU_WB_BYPASS_EN
   logic [19:0]  byp_raddr;
   logic [3:0]   byp_hit;
   logic [255:0] byp_data;
`endif

   rf_wb_buffer dut (
      .CLK       (clk),
      .RST       (rst),
      .IN_VALID  (in_valid),
      .IN_ADDR   (in_addr),
      .IN_DATA   (in_data),
      .IN_READY  (in_ready),
      .STALL     (stall),
      .WE        (we),
      .WADDR     (waddr),
      .WDATA     (wdata),
      .EMPTY     (empty)
`ifdef NCPU_WB_BYPASS_EN
      ,
      .BYP_RADDR (byp_raddr),
      .BYP_HIT   (byp_hit),
      .BYP_DATA  (byp_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit expired");
      $fatal(1, "watchdog");
   end

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        rst;
      logic [1:0]  v;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [63:0] d0;
      logic [63:0] d1;
      logic        st;
      logic        rdy;
      logic [1:0]  we;
      logic [4:0]  wa0;
      logic [4:0]  wa1;
      logic [63:0] wd0;
      logic [63:0] wd1;
      logic        emp;
   } vec_t;

   vec_t tbl [15];

   logic [4:0]  sb_a [$];
   logic [63:0] sb_d [$];
   int          exp_count = 0;

   function automatic vec_t mk(
      input logic r, input logic [1:0] v,
      input logic [4:0] a0, input logic [4:0] a1,
      input logic [63:0] d0, input logic [63:0] d1, input logic st,
      input logic rdy, input logic [1:0] w,
      input logic [4:0] wa0, input logic [4:0] wa1,
      input logic [63:0] wd0, input logic [63:0] wd1, input logic emp);
      vec_t t;
      t.rst = r;  t.v = v;  t.a0 = a0;  t.a1 = a1;
      t.d0 = d0;  t.d1 = d1;  t.st = st;
      t.rdy = rdy;  t.we = w;  t.wa0 = wa0;  t.wa1 = wa1;
      t.wd0 = wd0;  t.wd1 = wd1;  t.emp = emp;
      return t;
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_we(input string tag);
      for (int i = 0; i < 2; i++) begin
         if (we[i]) begin
            if (sb_a.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL %s_extra: got WE lane %0d with nothing queued, expected none",
                        tag, i);
            end else begin
               chk({tag, "_waddr"}, 64'(waddr[i*5 +: 5]), 64'(sb_a[0]));
               chk({tag, "_wdata"}, wdata[i*64 +: 64], sb_d[0]);
               void'(sb_a.pop_front());
               void'(sb_d.pop_front());
            end
         end
      end
   endtask

   task automatic cyc(input logic [1:0] v, input logic st, input string tag);
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [63:0] d0;
      logic [63:0] d1;
      int          n;
      int          pushed;
      logic        rdy;
      a0 = 5'($urandom_range(0, 31));
      a1 = 5'($urandom_range(0, 31));
      d0 = {$urandom, $urandom};
      d1 = {$urandom, $urandom};
      in_valid = v;
      in_addr  = {a1, a0};
      in_data  = {d1, d0};
      stall    = st;
      #1;
      rdy = (exp_count <= DEPTH - 2);
      chk({tag, "_rdy"}, 64'(in_ready), 64'(rdy));
      pushed = 0;
      if (rdy && v != 2'b00) begin
         if (v[0]) begin sb_a.push_back(a0); sb_d.push_back(d0); pushed++; end
         if (v[1]) begin sb_a.push_back(a1); sb_d.push_back(d1); pushed++; end
      end
      n = st ? 0 : (exp_count < 2 ? exp_count : 2);
      exp_count = exp_count + pushed - n;
      @(posedge clk);
      #1;
      chk({tag, "_we"}, 64'(we), (n == 2) ? 64'd3 : (n == 1) ? 64'd1 : 64'd0);
      check_we(tag);
   endtask

   initial begin
      tbl[0]  = mk(1, 2'b11, 1, 2, 0, 0, 0,     0, 2'b00, 0, 0, 0, 0, 1);
      tbl[1]  = mk(1, 2'b11, 1, 2, 0, 0, 0,     0, 2'b00, 0, 0, 0, 0, 1);
      tbl[2]  = mk(0, 2'b00, 0, 0, 0, 0, 0,     1, 2'b00, 0, 0, 0, 0, 1);
      tbl[3]  = mk(0, 2'b11, 3, 4, 64'hAA, 64'hBB, 0,
                   1, 2'b00, 0, 0, 0, 0, 1);
      tbl[4]  = mk(0, 2'b00, 0, 0, 0, 0, 0,     1, 2'b00, 0, 0, 0, 0, 0);
      tbl[5]  = mk(0, 2'b00, 0, 0, 0, 0, 0,
                   1, 2'b11, 3, 4, 64'hAA, 64'hBB, 0);
      tbl[6]  = mk(0, 2'b00, 0, 0, 0, 0, 0,     1, 2'b00, 0, 0, 0, 0, 1);
      tbl[7]  = mk(0, 2'b11, 5, 5, 1, 2, 0,     1, 2'b00, 0, 0, 0, 0, 1);
      tbl[8]  = mk(0, 2'b00, 0, 0, 0, 0, 0,     1, 2'b00, 0, 0, 0, 0, 0);
      tbl[9]  = mk(0, 2'b00, 0, 0, 0, 0, 0,     1, 2'b11, 5, 5, 1, 2, 0);
      tbl[10] = mk(0, 2'b00, 0, 0, 0, 0, 0,     1, 2'b00, 0, 0, 0, 0, 1);
      tbl[11] = mk(0, 2'b01, 9, 0, 64'h99, 0, 0, 1, 2'b00, 0, 0, 0, 0, 1);
      tbl[12] = mk(0, 2'b00, 0, 0, 0, 0, 0,     1, 2'b00, 0, 0, 0, 0, 0);
      tbl[13] = mk(0, 2'b00, 0, 0, 0, 0, 0,     1, 2'b01, 9, 0, 64'h99, 0, 0);
      tbl[14] = mk(0, 2'b00, 0, 0, 0, 0, 0,     1, 2'b00, 0, 0, 0, 0, 1);

      rst      = 1'b1;
      in_valid = 2'b00;
      in_addr  = '0;
      in_data  = '0;
      stall    = 1'b0;
`ifdef NCPU_WB_BYPASS_EN
      byp_raddr = '0;
`endif
      repeat (2) @(posedge clk);
      #1;

      // directed table: reset, basic push, WAW, single lane
      for (int k = 0; k < 15; k++) begin
         rst      = tbl[k].rst;
         in_valid = tbl[k].v;
         in_addr  = {tbl[k].a1, tbl[k].a0};
         in_data  = {tbl[k].d1, tbl[k].d0};
         stall    = tbl[k].st;
         #1;
         chk($sformatf("v%0d_rdy", k), 64'(in_ready), 64'(tbl[k].rdy));
         chk($sformatf("v%0d_we", k), 64'(we), 64'(tbl[k].we));
         chk($sformatf("v%0d_empty", k), 64'(empty), 64'(tbl[k].emp));
         if (tbl[k].we[0]) begin
            chk($sformatf("v%0d_wa0", k), 64'(waddr[4:0]), 64'(tbl[k].wa0));
            chk($sformatf("v%0d_wd0", k), wdata[63:0], tbl[k].wd0);
         end
         if (tbl[k].we[1]) begin
            chk($sformatf("v%0d_wa1", k), 64'(waddr[9:5]), 64'(tbl[k].wa1));
            chk($sformatf("v%0d_wd1", k), wdata[127:64], tbl[k].wd1);
         end
         @(posedge clk);
         #1;
      end

      // fill under stall until full, try a blocked push, then drain 2/cycle
      exp_count = 0;
      for (int g = 0; g < 4; g++)
         cyc(2'b11, 1'b1, $sformatf("fill%0d", g));
      chk("full_count", 64'(exp_count), 64'd8);
      cyc(2'b11, 1'b1, "full_block");
      for (int g = 0; g < 5; g++)
         cyc(2'b00, 1'b0, $sformatf("fdrain%0d", g));
      chk("full_drained", 64'(sb_a.size()), 64'd0);
      chk("full_empty", 64'(empty), 64'd1);

      // reset in the middle of operation drops buffered entries
      cyc(2'b11, 1'b0, "rst_push");
      rst      = 1'b1;
      in_valid = 2'b00;
      #1;
      chk("rst_mid_rdy", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("rst_mid_we", 64'(we), 64'd0);
      chk("rst_mid_empty", 64'(empty), 64'd1);
      rst = 1'b0;
      sb_a.delete();
      sb_d.delete();
      exp_count = 0;
      cyc(2'b00, 1'b0, "post_rst");

      // random traffic with stalls; pointers wrap several times
      for (int k = 0; k < 60; k++) begin
         int r;
         r = int'($urandom_range(0, 2));
         cyc(r == 0 ? 2'b00 : (r == 1 ? 2'b01 : 2'b11),
             ($urandom_range(0, 2) == 0), $sformatf("rnd%0d", k));
      end
      for (int k = 0; k < 6; k++)
         cyc(2'b00, 1'b0, $sformatf("rdrain%0d", k));
      chk("rnd_drained", 64'(sb_a.size()), 64'd0);
      chk("rnd_empty", 64'(empty), 64'd1);

`ifdef NCPU_WB_BYPASS_EN
      // two buffered writes to r7: the younger value must be returned
      stall    = 1'b1;
      in_valid = 2'b11;
      in_addr  = {5'd7, 5'd7};
      in_data  = {64'h22, 64'h11};
      @(posedge clk);
      #1;
      in_valid  = 2'b00;
      byp_raddr = {5'd0, 5'd0, 5'd8, 5'd7};
      #1;
      chk("byp_hit7", 64'(byp_hit[0]), 64'd1);
      chk("byp_data7", byp_data[63:0], 64'h22);
      chk("byp_hit8", 64'(byp_hit[1]), 64'd0);
      chk("byp_data8", byp_data[127:64], 64'd0);
      stall = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("byp_empty", 64'(empty), 64'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
